// File: rtl/multi_strobe_divider_pkg.sv
// -----------------------------------------------------------------------------
// multi_strobe_divider_pkg
// Shared types and helpers for the multi-channel strobe divider:
//   - sd_state_e : per-channel FSM state (IDLE, RUN, DONE)
//   - sd_mode_e  : channel mode (PERIODIC, ONE_SHOT)
//   - sd_clog2   : ceiling log2 usable in parameter expressions
//   - sd_sel_w   : width of a channel-select field, never less than 1 bit
// -----------------------------------------------------------------------------
package multi_strobe_divider_pkg;

  typedef enum logic [1:0] {
    SD_IDLE = 2'd0,
    SD_RUN  = 2'd1,
    SD_DONE = 2'd2
  } sd_state_e;

  typedef enum logic {
    SD_PERIODIC = 1'b0,
    SD_ONE_SHOT = 1'b1
  } sd_mode_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int unsigned sd_clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 32'd1;
      end
    end
    return result;
  endfunction

  // Channel-select width: a single channel still needs a 1-bit field.
  function automatic int unsigned sd_sel_w(input int unsigned channels);
    int unsigned w;
    w = sd_clog2(channels);
    if (w < 32'd1) begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/multi_strobe_divider_channel.sv
// -----------------------------------------------------------------------------
// strobe_div_channel
// One divider channel: shadow/active configuration registers, period counter
// and IDLE/RUN/DONE FSM. Emits a registered one-cycle strobe every Deff
// running cycles, Deff = max(D,1).
// Optional feature macro: STROBE_DIV_PHASE_EN (adds cfg_phase_i and a start
// phase applied on enable and on sync).
// Ports:
//   clk_i, nReset_i       clock, asynchronous active-low reset
//   en_i                  channel enable
//   sync_i                global restart (acts only in RUN)
//   wr_i                  decoded configuration write for this channel
//   cfg_div_i, cfg_mode_i new shadow divisor / mode
//   cfg_phase_i           new shadow phase (STROBE_DIV_PHASE_EN only)
//   strobe_o              registered one-cycle strobe
//   busy_o / done_o       registered RUN / DONE status
// -----------------------------------------------------------------------------
module strobe_div_channel
  import multi_strobe_divider_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk_i,
  input  logic             nReset_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic             cfg_mode_i,
`ifdef STROBE_DIV_PHASE_EN
  input  logic [CNT_W-1:0] cfg_phase_i,
`endif
  output logic             strobe_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  // Terminal count value Deff-1; a divisor of 0 behaves like 1.
  function automatic logic [CNT_W-1:0] term_of(input logic [CNT_W-1:0] d);
    if (d == ZERO) begin
      return ZERO;
    end else begin
      return d - ONE;
    end
  endfunction

  sd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  sd_mode_e         sh_mode_q, sh_mode_d;
  sd_mode_e         act_mode_q, act_mode_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] start_s;
`ifdef STROBE_DIV_PHASE_EN
  logic [CNT_W-1:0] sh_phase_q, sh_phase_d;
  logic [CNT_W-1:0] act_phase_q, act_phase_d;
  logic [CNT_W-1:0] ld_term_s;
`endif

  // Shadow update; the same _d values feed any reload this cycle, which
  // gives write-through when a write coincides with a reload event.
  always_comb begin
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    if (wr_i) begin
      sh_div_d  = cfg_div_i;
      sh_mode_d = sd_mode_e'(cfg_mode_i);
    end else begin
      sh_div_d  = sh_div_q;
      sh_mode_d = sh_mode_q;
    end
  end

`ifdef STROBE_DIV_PHASE_EN
  // Phase shadow and counter start value min(P, Deff-1) of the value being loaded.
  always_comb begin
    sh_phase_d = sh_phase_q;
    if (wr_i) begin
      sh_phase_d = cfg_phase_i;
    end else begin
      sh_phase_d = sh_phase_q;
    end
    ld_term_s = term_of(sh_div_d);
    if (sh_phase_d > ld_term_s) begin
      start_s = ld_term_s;
    end else begin
      start_s = sh_phase_d;
    end
  end
`else
  // Without the phase feature every start is from zero.
  always_comb begin
    start_s = ZERO;
  end
`endif

  // Channel FSM, counter and reload next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    act_mode_d = act_mode_q;
    strobe_d   = 1'b0;
`ifdef STROBE_DIV_PHASE_EN
    act_phase_d = act_phase_q;
`endif
    case (state_q)
      SD_IDLE: begin
        if (en_i) begin
          state_d    = SD_RUN;
          cnt_d      = start_s;
          act_div_d  = sh_div_d;
          act_mode_d = sh_mode_d;
`ifdef STROBE_DIV_PHASE_EN
          act_phase_d = sh_phase_d;
`endif
        end else begin
          state_d = SD_IDLE;
          cnt_d   = ZERO;
        end
      end
      SD_RUN: begin
        if (!en_i) begin
          state_d = SD_IDLE;
          cnt_d   = ZERO;
        end else if (sync_i) begin
          // Sync beats a coincident terminal count: restart, no strobe.
          state_d    = SD_RUN;
          cnt_d      = start_s;
          act_div_d  = sh_div_d;
          act_mode_d = sh_mode_d;
`ifdef STROBE_DIV_PHASE_EN
          act_phase_d = sh_phase_d;
`endif
        end else if (cnt_q == term_of(act_div_q)) begin
          cnt_d      = ZERO;
          strobe_d   = 1'b1;
          act_div_d  = sh_div_d;
          act_mode_d = sh_mode_d;
`ifdef STROBE_DIV_PHASE_EN
          act_phase_d = sh_phase_d;
`endif
          // The mode of the period that just ended decides one-shot.
          if (act_mode_q == SD_ONE_SHOT) begin
            state_d = SD_DONE;
          end else begin
            state_d = SD_RUN;
          end
        end else begin
          state_d = SD_RUN;
          cnt_d   = cnt_q + ONE;
        end
      end
      SD_DONE: begin
        cnt_d = ZERO;
        if (!en_i) begin
          state_d = SD_IDLE;
        end else begin
          state_d = SD_DONE;
        end
      end
      default: begin
        state_d = SD_IDLE;
        cnt_d   = ZERO;
      end
    endcase
    busy_d = (state_d == SD_RUN);
    done_d = (state_d == SD_DONE);
  end

  // State, counter, configuration and output registers.
  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      state_q    <= SD_IDLE;
      cnt_q      <= ZERO;
      sh_div_q   <= DEF_DIV;
      act_div_q  <= DEF_DIV;
      sh_mode_q  <= SD_PERIODIC;
      act_mode_q <= SD_PERIODIC;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef STROBE_DIV_PHASE_EN
      sh_phase_q  <= ZERO;
      act_phase_q <= ZERO;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_div_q   <= sh_div_d;
      act_div_q  <= act_div_d;
      sh_mode_q  <= sh_mode_d;
      act_mode_q <= act_mode_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef STROBE_DIV_PHASE_EN
      sh_phase_q  <= sh_phase_d;
      act_phase_q <= act_phase_d;
`endif
    end
  end

  assign strobe_o = strobe_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: rtl/multi_strobe_divider.sv
// -----------------------------------------------------------------------------
// multi_strobe_divider
// CHANNELS independent programmable strobe dividers sharing one write port
// and one global sync. Writes addressed beyond CHANNELS-1 match no channel.
// Optional feature macro: STROBE_DIV_PHASE_EN (adds cfg_phase_i).
// Ports:
//   clk_i, nReset_i   clock, asynchronous active-low reset
//   en_i              per-channel enable
//   sync_i            restart all running channels
//   cfg_we_i          configuration write strobe
//   cfg_ch_i          target channel
//   cfg_div_i         divisor D
//   cfg_mode_i        0 periodic, 1 one-shot
//   cfg_phase_i       start phase P (STROBE_DIV_PHASE_EN only)
//   strobe_o          per-channel registered strobe
//   busy_o / done_o   per-channel RUN / DONE status
// -----------------------------------------------------------------------------
module multi_strobe_divider
  import multi_strobe_divider_pkg::*;
#(
  parameter  int unsigned CHANNELS    = 4,
  parameter  int unsigned CNT_W       = 16,
  parameter  int unsigned DEFAULT_DIV = 10,
  localparam int unsigned CH_W        = sd_sel_w(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                nReset_i,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                sync_i,
  input  logic                cfg_we_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [CNT_W-1:0]    cfg_div_i,
  input  logic                cfg_mode_i,
`ifdef STROBE_DIV_PHASE_EN
  input  logic [CNT_W-1:0]    cfg_phase_i,
`endif
  output logic [CHANNELS-1:0] strobe_o,
  output logic [CHANNELS-1:0] busy_o,
  output logic [CHANNELS-1:0] done_o
);

  logic [CHANNELS-1:0] wr_sel_s;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign wr_sel_s[g] = cfg_we_i & (cfg_ch_i == CH_W'(g));

    strobe_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i       (clk_i),
      .nReset_i    (nReset_i),
      .en_i        (en_i[g]),
      .sync_i      (sync_i),
      .wr_i        (wr_sel_s[g]),
      .cfg_div_i   (cfg_div_i),
      .cfg_mode_i  (cfg_mode_i),
`ifdef STROBE_DIV_PHASE_EN
      .cfg_phase_i (cfg_phase_i),
`endif
      .strobe_o    (strobe_o[g]),
      .busy_o      (busy_o[g]),
      .done_o      (done_o[g])
    );
  end

endmodule

// File: tb/tb_multi_strobe_divider.sv
module tb_multi_strobe_divider;

  localparam int CHANNELS    = 4;
  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 10;
  localparam int CH_W        = 2;

  logic                clk_i = 1'b0;
  logic                nReset_i;
  logic [CHANNELS-1:0] en_i;
  logic                sync_i;
  logic                cfg_we_i;
  logic [CH_W-1:0]     cfg_ch_i;
  logic [CNT_W-1:0]    cfg_div_i;
  logic                cfg_mode_i;
`ifdef STROBE_DIV_PHASE_EN
  logic [CNT_W-1:0]    cfg_phase_i;
`endif
  logic [CHANNELS-1:0] strobe_o;
  logic [CHANNELS-1:0] busy_o;
  logic [CHANNELS-1:0] done_o;

  always #5 clk_i = ~clk_i;

  multi_strobe_divider #(
    .CHANNELS    (CHANNELS),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk_i       (clk_i),
    .nReset_i    (nReset_i),
    .en_i        (en_i),
    .sync_i      (sync_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_ch_i    (cfg_ch_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_mode_i  (cfg_mode_i),
`ifdef STROBE_DIV_PHASE_EN
    .cfg_phase_i (cfg_phase_i),
`endif
    .strobe_o    (strobe_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CHANNELS-1:0] strobe;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: m_rem = edges left until the terminal-count edge.
  int m_state [CHANNELS];  // 0 idle, 1 run, 2 done
  int m_rem   [CHANNELS];
  int m_sh_div[CHANNELS];
  int m_sh_md [CHANNELS];
  int m_sh_ph [CHANNELS];
  int m_ac_div[CHANNELS];
  int m_ac_md [CHANNELS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int deff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_state[i]  = 0;
      m_rem[i]    = 0;
      m_sh_div[i] = DEFAULT_DIV;
      m_sh_md[i]  = 0;
      m_sh_ph[i]  = 0;
      m_ac_div[i] = DEFAULT_DIV;
      m_ac_md[i]  = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step(output exp_t e);
    e = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bit wr;
      int nd, nm, np, st;
      wr = cfg_we_i && (int'(cfg_ch_i) == i);
      nd = wr ? int'(cfg_div_i) : m_sh_div[i];
      nm = wr ? int'(cfg_mode_i) : m_sh_md[i];
`ifdef STROBE_DIV_PHASE_EN
      np = wr ? int'(cfg_phase_i) : m_sh_ph[i];
      st = (np < deff(nd) - 1) ? np : deff(nd) - 1;
`else
      np = 0;
      st = 0;
`endif
      case (m_state[i])
        0: if (en_i[i]) begin
             m_state[i] = 1; m_ac_div[i] = nd; m_ac_md[i] = nm;
             m_rem[i] = deff(nd) - st;
           end
        1: if (!en_i[i]) begin
             m_state[i] = 0;
           end else if (sync_i) begin
             m_ac_div[i] = nd; m_ac_md[i] = nm;
             m_rem[i] = deff(nd) - st;
           end else begin
             m_rem[i]--;
             if (m_rem[i] == 0) begin
               e.strobe[i] = 1'b1;
               if (m_ac_md[i] == 1) m_state[i] = 2;
               m_ac_div[i] = nd; m_ac_md[i] = nm;
               m_rem[i] = deff(nd);
             end
           end
        default: if (!en_i[i]) m_state[i] = 0;
      endcase
      m_sh_div[i] = nd;
      m_sh_md[i]  = nm;
      m_sh_ph[i]  = np;
      e.busy[i] = (m_state[i] == 1);
      e.done[i] = (m_state[i] == 2);
    end
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    exp_t got;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    got = exp_q.pop_front();
    chk("strobe_o", 32'(strobe_o), 32'(got.strobe));
    chk("busy_o",   32'(busy_o),   32'(got.busy));
    chk("done_o",   32'(done_o),   32'(got.done));
    sync_i   = 1'b0;
    cfg_we_i = 1'b0;
  endtask

  task automatic write_cfg(input logic [CH_W-1:0] ch, input int dv, input logic md, input int ph);
    cfg_we_i   = 1'b1;
    cfg_ch_i   = ch;
    cfg_div_i  = CNT_W'(dv);
    cfg_mode_i = md;
`ifdef STROBE_DIV_PHASE_EN
    cfg_phase_i = CNT_W'(ph);
`else
    if (ph != 0) $display("note: phase ignored in this build");
`endif
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_strobe"}, 32'(strobe_o), 32'd0);
    chk({tag, "_busy"},   32'(busy_o),   32'd0);
    chk({tag, "_done"},   32'(done_o),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset_i = 1'b0; en_i = '0; sync_i = 1'b0; cfg_we_i = 1'b0;
    cfg_ch_i = '0; cfg_div_i = '0; cfg_mode_i = 1'b0;
`ifdef STROBE_DIV_PHASE_EN
    cfg_phase_i = '0;
`endif
    model_reset();
    #2;
    check_zero_outputs("reset");
    @(posedge clk_i); #1;
    check_zero_outputs("reset_edge");
    nReset_i = 1'b1;

    // Defaults on ch0: strobes 10, 20, 30 cycles after the enable edge.
    en_i = 4'b0001;
    for (int i = 0; i < 35; i++) begin
      step();
      chk("t1_ch0_strobe", 32'(strobe_o[0]), 32'((i > 0) && (i % 10 == 0)));
      chk("t1_ch0_busy", 32'(busy_o[0]), 32'd1);
    end

    // One-shot ch1 with D=3.
    en_i = 4'b0000;
    step();
    write_cfg(2'd1, 3, 1'b1, 0);
    step();
    en_i = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_ch1_strobe", 32'(strobe_o[1]), 32'(i == 3));
      chk("t2_ch1_done", 32'(done_o[1]), 32'(i >= 3));
    end
    en_i = 4'b0000;
    step();
    chk("t2_ch1_idle", 32'({busy_o[1], done_o[1]}), 32'd0);

    // Mid-period write on ch0: period of 10 completes, then every 4.
    en_i = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      if (i == 6) write_cfg(2'd0, 4, 1'b0, 0);
      step();
      chk("t3_ch0_strobe", 32'(strobe_o[0]), 32'((i == 10) || ((i > 10) && ((i - 10) % 4 == 0))));
    end

    // Sync on ch0 terminal count: strobe suppressed, next one Deff later.
    en_i = 4'b0000;
    step();
    write_cfg(2'd0, 10, 1'b0, 0);
    step();
    en_i = 4'b0001;
    for (int i = 0; i < 23; i++) begin
      if (i == 10) sync_i = 1'b1;
      step();
      chk("t4_ch0_strobe", 32'(strobe_o[0]), 32'(i == 20));
      chk("t4_ch2_idle", 32'(busy_o[2]), 32'd0);
    end

    // D=0 on ch2, D=1 on ch3: continuous strobe while enabled.
    en_i = 4'b0000;
    step();
    write_cfg(2'd2, 0, 1'b0, 0);
    step();
    write_cfg(2'd3, 1, 1'b0, 0);
    step();
    en_i = 4'b1100;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_ch23_strobe", 32'(strobe_o[3:2]), (i >= 1) ? 32'd3 : 32'd0);
    end
    en_i = 4'b0000;
    step();
    chk("t5_drop_strobe", 32'(strobe_o), 32'd0);

`ifdef STROBE_DIV_PHASE_EN
    // Phase P=7 with D=10: first strobe 3 cycles after enable.
    write_cfg(2'd0, 10, 1'b0, 7);
    step();
    en_i = 4'b0001;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("t6_phase_strobe", 32'(strobe_o[0]), 32'((i == 3) || (i == 13)));
    end
    en_i = 4'b0000;
    step();
    write_cfg(2'd0, 10, 1'b0, 0);
    step();
`endif

    // Randomised traffic with small divisors.
    for (int i = 0; i < 300; i++) begin
      en_i   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : en_i;
      sync_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) begin
        write_cfg(CH_W'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                  1'($urandom_range(0, 1)), 0);
`ifdef STROBE_DIV_PHASE_EN
        cfg_phase_i = CNT_W'($urandom_range(0, 7));
`endif
      end
      step();
    end

    // Reset mid-period, then release with en_i[0] already high.
    en_i = 4'b0000;
    step();
    en_i = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    nReset_i = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("midrst");
    @(posedge clk_i); #1;
    check_zero_outputs("midrst_edge");
    nReset_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t7_ch0_strobe", 32'(strobe_o[0]), 32'(i == DEFAULT_DIV));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
